// File: rtl/block_update_ctrl.sv
// Video-slot write sequencer: commits shadowed register updates and streams pixel
// loads into block RAM, only while the frame counter is in vertical blank.
module block_update_ctrl #(
    parameter int CD         = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int V_ACTIVE   = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic [10:0]   upd_x0,
    input  logic [10:0]   upd_y0,
    input  logic [3:0]    upd_ctrl,
    input  logic          upd_bypass,
    input  logic          load_start,
    input  logic [12:0]   load_len,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic [CD-1:0] px_data,
    output logic          cs,
    output logic          write,
    output logic [13:0]   addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          commit_done,
    output logic          load_done
);

    typedef enum logic [2:0] {IDLE, LOAD, C_BYP, C_X0, C_Y0, C_CTRL} state_t;

    localparam logic [12:0] MAX_LEN = 13'(1 << ADDR_WIDTH);

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic        load_active_q, load_active_d;
    logic [12:0] cnt_q, cnt_d;
    logic [12:0] len_q, len_d;
    logic [10:0] x0_q, x0_d;
    logic [10:0] y0_q, y0_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        byp_q, byp_d;
    logic        cs_q, cs_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        commit_done_q, commit_done_d;
    logic        load_done_q, load_done_d;

    logic vblank, px_fire, upd_fire;
    logic unused_x;

    assign unused_x    = ^x;
    assign vblank      = (y >= 11'(V_ACTIVE));
    assign upd_ready   = ~pending_q;
    assign px_ready    = (state_q == LOAD) & vblank & ~pending_q;
    assign px_fire     = px_valid & px_ready;
    assign upd_fire    = upd_valid & ~pending_q;
    assign busy        = pending_q | load_active_q | (state_q != IDLE);

    assign cs          = cs_q;
    assign write       = cs_q;
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;
    assign commit_done = commit_done_q;
    assign load_done   = load_done_q;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        load_active_d = load_active_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        ctrl_d        = ctrl_q;
        byp_d         = byp_q;
        cs_d          = 1'b0;
        addr_d        = '0;
        wr_data_d     = '0;
        commit_done_d = 1'b0;
        load_done_d   = 1'b0;

        if (upd_fire) begin
            x0_d      = upd_x0;
            y0_d      = upd_y0;
            ctrl_d    = upd_ctrl;
            byp_d     = upd_bypass;
            pending_d = 1'b1;
        end

        if (load_start && !load_active_q && load_len != 13'd0 && load_len <= MAX_LEN) begin
            load_active_d = 1'b1;
            len_d         = load_len;
            cnt_d         = '0;
        end

        case (state_q)
            IDLE: begin
                if (pending_q && vblank)
                    state_d = C_BYP;
                else if (load_active_q)
                    state_d = LOAD;
            end
            LOAD: begin
                // px_ready is low while pending, so a commit always lands between pixels
                if (pending_q && vblank) begin
                    state_d = C_BYP;
                end else if (px_fire) begin
                    cs_d      = 1'b1;
                    addr_d    = 14'(cnt_q[ADDR_WIDTH-1:0]);
                    wr_data_d = 32'(px_data);
                    cnt_d     = cnt_q + 13'd1;
                    if (cnt_q == len_q - 13'd1) begin
                        load_active_d = 1'b0;
                        load_done_d   = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            C_BYP: begin
                cs_d      = 1'b1;
                addr_d    = 14'h2000;
                wr_data_d = 32'(byp_q);
                state_d   = C_X0;
            end
            C_X0: begin
                cs_d      = 1'b1;
                addr_d    = 14'h2001;
                wr_data_d = 32'(x0_q);
                state_d   = C_Y0;
            end
            C_Y0: begin
                cs_d      = 1'b1;
                addr_d    = 14'h2002;
                wr_data_d = 32'(y0_q);
                state_d   = C_CTRL;
            end
            C_CTRL: begin
                cs_d          = 1'b1;
                addr_d        = 14'h2003;
                wr_data_d     = 32'(ctrl_q);
                commit_done_d = 1'b1;
                pending_d     = 1'b0;
                state_d       = load_active_q ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            load_active_q <= 1'b0;
            cnt_q         <= '0;
            len_q         <= '0;
            x0_q          <= '0;
            y0_q          <= '0;
            ctrl_q        <= '0;
            byp_q         <= 1'b0;
            cs_q          <= 1'b0;
            addr_q        <= '0;
            wr_data_q     <= '0;
            commit_done_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            load_active_q <= load_active_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            ctrl_q        <= ctrl_d;
            byp_q         <= byp_d;
            cs_q          <= cs_d;
            addr_q        <= addr_d;
            wr_data_q     <= wr_data_d;
            commit_done_q <= commit_done_d;
            load_done_q   <= load_done_d;
        end
    end

endmodule

// File: tb/tb_block_update_ctrl.sv
// Scoreboard bench for block_update_ctrl: expected writes are queued at each
// accepted handshake and matched against the write bus in order.
module tb_block_update_ctrl;

    localparam int CD = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [10:0]   x = '0;
    logic [10:0]   y = '0;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [10:0]   upd_x0 = '0;
    logic [10:0]   upd_y0 = '0;
    logic [3:0]    upd_ctrl = '0;
    logic          upd_bypass = 1'b0;
    logic          load_start = 1'b0;
    logic [12:0]   load_len = '0;
    logic          px_valid = 1'b0;
    logic          px_ready;
    logic [CD-1:0] px_data;
    logic          cs, write;
    logic [13:0]   addr;
    logic [31:0]   wr_data;
    logic          busy, commit_done, load_done;

    block_update_ctrl #(.CD(CD), .ADDR_WIDTH(12), .V_ACTIVE(480)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_x0(upd_x0), .upd_y0(upd_y0), .upd_ctrl(upd_ctrl), .upd_bypass(upd_bypass),
        .load_start(load_start), .load_len(load_len),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
        .busy(busy), .commit_done(commit_done), .load_done(load_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
        logic        cdone;
        logic        ldone;
    } exp_t;

    exp_t exp_q[$];
    int total = 0, bad = 0;
    int wr_cnt = 0, idle_bad = 0;
    int acc_cnt = 0, ld_base = 0, ld_len = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, expv);
        end
    endtask

    function automatic logic [11:0] pat(input int i);
        return 12'((i * 37 + 5) & 32'hFFF);
    endfunction

    assign px_data = pat(acc_cnt - ld_base);

    // queue expected writes at each accepted handshake
    always @(posedge clk) begin
        exp_t e;
        int idx;
        if (!reset && px_valid && px_ready) begin
            idx     = acc_cnt - ld_base;
            e.addr  = 14'(idx);
            e.data  = 32'(pat(idx));
            e.cdone = 1'b0;
            e.ldone = (idx == ld_len - 1);
            exp_q.push_back(e);
            acc_cnt <= acc_cnt + 1;
        end
        if (!reset && upd_valid && upd_ready) begin
            e.ldone = 1'b0;
            e.cdone = 1'b0;
            e.addr = 14'h2000; e.data = 32'(upd_bypass); exp_q.push_back(e);
            e.addr = 14'h2001; e.data = 32'(upd_x0);     exp_q.push_back(e);
            e.addr = 14'h2002; e.data = 32'(upd_y0);     exp_q.push_back(e);
            e.addr = 14'h2003; e.data = 32'(upd_ctrl); e.cdone = 1'b1; exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cs || write) begin
            wr_cnt++;
            chk("cs_eq_write", 64'(write), 64'(cs));
            chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(addr), 64'(e.addr));
                chk("wr_data", 64'(wr_data), 64'(e.data));
                chk("commit_done", 64'(commit_done), 64'(e.cdone));
                chk("load_done", 64'(load_done), 64'(e.ldone));
            end
        end else if (addr != 0 || wr_data != 0 || commit_done || load_done) begin
            idle_bad++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_upd(input logic [10:0] x0, input logic [10:0] y0,
                            input logic [3:0] c, input logic b);
        upd_valid = 1'b1; upd_x0 = x0; upd_y0 = y0; upd_ctrl = c; upd_bypass = b;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic start_load(input int len);
        ld_base    = acc_cnt;
        ld_len     = len;
        load_start = 1'b1;
        load_len   = 13'(len);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int need_px, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || (acc_cnt - ld_base) < need_px) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    initial begin
        int base, n, rdy_seen;

        cyc(3);
        #1;
        chk("rst_cs", 64'(cs), 0);
        chk("rst_write", 64'(write), 0);
        chk("rst_addr", 64'(addr), 0);
        chk("rst_wr_data", 64'(wr_data), 0);
        chk("rst_commit_done", 64'(commit_done), 0);
        chk("rst_load_done", 64'(load_done), 0);
        chk("rst_upd_ready", 64'(upd_ready), 1);
        chk("rst_px_ready", 64'(px_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);

        // register commit waits for vblank
        y = 11'd200;
        send_upd(11'd100, 11'd50, 4'd3, 1'b0);
        chk("upd_ready_pending", 64'(upd_ready), 0);
        chk("busy_pending", 64'(busy), 1);
        cyc(10);
        chk("no_wr_active", 64'(wr_cnt), 0);
        y = 11'd480;
        wait_drain("commit1_drain", 0, 50);
        chk("commit1_count", 64'(wr_cnt), 4);
        y = 11'd0;
        cyc(2);
        chk("busy_after_commit", 64'(busy), 0);

        // short load armed just before vblank
        y = 11'd479;
        px_valid = 1'b1;
        base = wr_cnt;
        start_load(4);
        cyc(5);
        #1;
        chk("px_ready_pre_vblank", 64'(px_ready), 0);
        chk("no_wr_pre_vblank", 64'(wr_cnt - base), 0);
        y = 11'd480;
        wait_drain("load4_drain", 4, 50);
        chk("load4_count", 64'(wr_cnt - base), 4);
        px_valid = 1'b0;
        cyc(2);
        chk("busy_after_load4", 64'(busy), 0);

        // full-size load split across two frames
        y = 11'd480;
        px_valid = 1'b1;
        start_load(4096);
        n = 0;
        while ((acc_cnt - ld_base) < 1000 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        y = 11'd0;
        chk("pause_at_1000", 64'(acc_cnt - ld_base), 1000);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            y = 11'(i * 11);
            #1;
            if (px_ready) rdy_seen++;
        end
        chk("px_ready_active_lines", 64'(rdy_seen), 0);
        chk("no_px_active_lines", 64'(acc_cnt - ld_base), 1000);
        @(negedge clk);
        y = 11'd480;
        wait_drain("load4096_drain", 4096, 5000);
        px_valid = 1'b0;
        cyc(2);
        chk("busy_after_load4096", 64'(busy), 0);

        // commit preempts a running load
        base = wr_cnt;
        px_valid = 1'b1;
        start_load(8);
        n = 0;
        while ((acc_cnt - ld_base) < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        send_upd(11'd7, 11'd9, 4'd5, 1'b1);
        wait_drain("preempt_drain", 8, 100);
        chk("preempt_count", 64'(wr_cnt - base), 12);
        px_valid = 1'b0;
        cyc(2);

        // second update while pending is refused; bad load lengths ignored
        y = 11'd200;
        base = wr_cnt;
        send_upd(11'd1, 11'd2, 4'd4, 1'b1);
        upd_valid = 1'b1; upd_x0 = 11'd11; upd_y0 = 11'd22; upd_ctrl = 4'd9; upd_bypass = 1'b0;
        #1;
        chk("upd_ready_second", 64'(upd_ready), 0);
        @(negedge clk);
        upd_valid = 1'b0;
        y = 11'd480;
        wait_drain("commit2_drain", 0, 50);
        chk("commit2_count", 64'(wr_cnt - base), 4);
        y = 11'd0;
        cyc(2);
        start_load(0);
        cyc(3);
        chk("busy_len0", 64'(busy), 0);
        start_load(5000);
        cyc(3);
        chk("busy_len5000", 64'(busy), 0);

        // reset in the middle of a commit
        y = 11'd480;
        send_upd(11'd3, 11'd4, 4'd1, 1'b0);
        n = 0;
        while (!(cs && addr == 14'h2000) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("saw_first_commit_wr", 64'(n < 20), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_cs", 64'(cs), 0);
        chk("rst_mid_write", 64'(write), 0);
        exp_q.delete();
        cyc(2);
        reset = 1'b0;
        #1;
        chk("post_rst_upd_ready", 64'(upd_ready), 1);
        chk("post_rst_busy", 64'(busy), 0);
        base = wr_cnt;
        cyc(20);
        chk("post_rst_no_wr", 64'(wr_cnt - base), 0);

        chk("idle_bus_zero", 64'(idle_bad), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
